output_limiter: RTL
===================

// Module: output_limiter
// PURPOSE
// - Back end of the overdrive chain. Takes the 32-bit signed clipped sample from the overdrive and returns it to the 16-bit signed output domain.
// - Smooth gain reduction: attack/release envelope follower plus a sequential divider, then a final hard saturation.
// - Sits between the overdrive output register and the DAC/codec serializer. Uses a valid/ready handshake on input and a one-cycle valid pulse on output.
// PARAMETERS
// THRESH         32767  envelope level (|sample| units) above which gain reduction starts
// ATTACK_SHIFT   1      envelope rise coefficient 2^-ATTACK_SHIFT per accepted sample
// RELEASE_SHIFT  8      envelope fall coefficient 2^-RELEASE_SHIFT per accepted sample
// GAIN_FRAC      15     fractional bits of gain; unity gain = 2^GAIN_FRAC
// PORTS
// clk         in   1   system clock, all state on rising edge
// rst         in   1   asynchronous, active-high reset
// in_valid    in   1   in_sample valid this cycle
// in_ready    out  1   block can accept a sample (high only in IDLE)
// in_sample   in   32  signed sample from overdrive
// ou_valid    out  1   one-cycle pulse; ou_sample/ou_gain valid
// ou_sample   out  16  signed limited sample
// ou_gain     out  16  unsigned gain applied to last sample, Q1.GAIN_FRAC
// BEHAVIOUR
// - Reset (async, immediate) clears everything:
//   - state=IDLE, env=0, ou_valid=0, ou_sample=0, ou_gain=0.
//   - in_ready=1 as soon as rst deasserts.
// - FSM states: IDLE -> ENV -> (DIV x16) -> MUL -> IDLE.
//   - IDLE: in_ready=1. On in_valid&&in_ready, capture x=in_sample and go to ENV.
//   - ENV, magnitude and envelope update:
//     - a=|x|; x=-2^31 gives a=2^31-1.
//     - env is 31-bit unsigned.
//     - a>env: env += (a-env)>>ATTACK_SHIFT.
//     - else: env -= (env-a)>>RELEASE_SHIFT.
//     - Go to DIV if the updated env>THRESH.
//     - Otherwise gain=2^GAIN_FRAC and go to MUL.
//   - DIV: restoring divide, one quotient bit per cycle, MSB first, exactly 16 cycles.
//     - gain=floor(THRESH*2^GAIN_FRAC / env).
//     - env>THRESH guarantees gain<2^GAIN_FRAC.
//   - MUL: p = x(signed 32) * gain(unsigned 16), 48-bit.
//     - y = p>>>GAIN_FRAC (arithmetic, floor).
//     - Saturate y to [-32768, 32767].
//     - Register ou_sample=y and ou_gain=gain; go to IDLE.
// - Output handshake:
//   - ou_valid is high exactly one cycle: the first IDLE cycle after MUL.
//   - ou_sample and ou_gain hold their values until the next MUL.
// - in_ready is low in ENV, DIV and MUL.
//   - in_valid during those states is ignored; no buffering, the upstream holds or drops.
//   - A new sample may be accepted in the same cycle ou_valid is high.
// - Latency from the accepting edge to ou_valid high: 3 cycles with no reduction, 19 cycles with reduction.
// - env persists across samples; only rst clears it.
// - Reset mid-operation (any state): the in-flight sample is discarded and no ou_valid is produced for it.
// - Arithmetic rules:
//   - No intermediate overflow: env update stays within 31 bits, and the product is full 48-bit.
//   - Saturation is applied only at the output.
// TESTING
// - Reset: assert rst mid-stream -> ou_valid=0, ou_sample=0, ou_gain=0 immediately; in_ready=1 the cycle after release.
// - Sub-threshold, env=0: in_sample=1000 -> env=500, ou_sample=1000, ou_gain=32768, ou_valid 3 cycles after accept.
// - Over-threshold, env=0: in_sample=200000 -> env=100000, ou_gain=10737, ou_sample=32767 (saturated), ou_valid 19 cycles after accept.
// - Negative extreme: in_sample=-2^31 -> a=2^31-1, ou_sample=-32768, ou_gain<32768, no overflow X/wrap.
// - Release: after case 3, feed in_sample=0 repeatedly -> env decays by env>>8 per sample; ou_gain rises monotonically back to 32768 once env<=32767.
// - Backpressure: hold in_valid=1 with changing data during DIV -> only samples presented while in_ready=1 are processed, one ou_valid per accept.

Source files
------------

// File: rtl/output_limiter.sv
// Output limiter: envelope-driven gain reduction with a sequential divider and a final hard
// saturation, taking a 32-bit signed sample back to the 16-bit signed output domain.
module output_limiter #(
  parameter int unsigned THRESH        = 32767,
  parameter int unsigned ATTACK_SHIFT  = 1,
  parameter int unsigned RELEASE_SHIFT = 8,
  parameter int unsigned GAIN_FRAC     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_sample,
  output logic        ou_valid,
  output logic [15:0] ou_sample,
  output logic [15:0] ou_gain
);

  localparam int unsigned RemW = 31 + GAIN_FRAC;
  localparam logic [RemW-1:0] Numer = RemW'(THRESH) << GAIN_FRAC;
  localparam logic [30:0] ThreshW = 31'(THRESH);
  localparam logic [15:0] UnityGain = 16'(1 << GAIN_FRAC);

  typedef enum logic [1:0] {StIdle, StEnv, StDiv, StMul} state_e;

  state_e          state_q;
  logic [31:0]     x_q;
  logic [30:0]     env_q;
  logic [RemW-1:0] rem_q;
  logic [RemW-1:0] dsh_q;
  logic [15:0]     gain_q;
  logic [3:0]      cnt_q;

  logic [30:0]        mag;
  logic [30:0]        env_nxt;
  logic [47:0]        prod;
  logic signed [47:0] y;
  logic [15:0]        y_sat;
  logic               rem_ge;

  assign in_ready = (state_q == StIdle);

  always_comb begin
    // -2^31 has no positive counterpart in 32 bits; clamp its magnitude to 2^31-1
    mag = 31'h0;
    if (!x_q[31]) begin
      mag = x_q[30:0];
    end else if (x_q == 32'h8000_0000) begin
      mag = 31'h7fff_ffff;
    end else begin
      mag = 31'(32'h0 - x_q);
    end

    env_nxt = env_q;
    if (mag > env_q) begin
      env_nxt = env_q + ((mag - env_q) >> ATTACK_SHIFT);
    end else begin
      env_nxt = env_q - ((env_q - mag) >> RELEASE_SHIFT);
    end

    // Sign-extended x times zero-extended gain; the low 48 bits are the exact signed product
    prod = {{16{x_q[31]}}, x_q} * {32'h0, gain_q};
    y    = $signed(prod) >>> GAIN_FRAC;

    y_sat = y[15:0];
    if (y > 48'sd32767) begin
      y_sat = 16'h7fff;
    end else if (y < -48'sd32768) begin
      y_sat = 16'h8000;
    end

    rem_ge = (rem_q >= dsh_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= 32'h0;
      env_q     <= 31'h0;
      rem_q     <= '0;
      dsh_q     <= '0;
      gain_q    <= 16'h0;
      cnt_q     <= 4'h0;
      ou_valid  <= 1'b0;
      ou_sample <= 16'h0;
      ou_gain   <= 16'h0;
    end else begin
      ou_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q     <= in_sample;
            state_q <= StEnv;
          end
        end
        StEnv: begin
          env_q <= env_nxt;
          if (env_nxt > ThreshW) begin
            rem_q   <= Numer;
            dsh_q   <= RemW'(env_nxt) << GAIN_FRAC;
            gain_q  <= 16'h0;
            cnt_q   <= 4'h0;
            state_q <= StDiv;
          end else begin
            gain_q  <= UnityGain;
            state_q <= StMul;
          end
        end
        StDiv: begin
          // Restoring divide: divisor starts at env<<15 and walks down one bit per cycle
          if (rem_ge) begin
            rem_q <= rem_q - dsh_q;
          end
          gain_q <= {gain_q[14:0], rem_ge};
          dsh_q  <= dsh_q >> 1;
          cnt_q  <= cnt_q + 4'h1;
          if (cnt_q == 4'hf) begin
            state_q <= StMul;
          end
        end
        StMul: begin
          ou_sample <= y_sat;
          ou_gain   <= gain_q;
          ou_valid  <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
